// File: rtl/memory_access_ctrl_pkg.sv
// Shared types and default sizes for the memory access controller.
// MEM_INIT_EN selects the reset state (INIT instead of IDLE).
package memory_ctrl_pkg;

  localparam int DATA_LENGTH = 8;
  localparam int ADDR_LENGTH = 4;
  localparam int MEM_DEPTH   = 2**ADDR_LENGTH;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } ctrl_state_t;

  function automatic ctrl_state_t reset_state();
`ifdef MEM_INIT_EN
    return INIT;
`else
    return IDLE;
`endif
  endfunction

endpackage

// File: rtl/memory_access_ctrl.sv
// Valid/ready front end for a single-port synchronous memory with a registered read port.
// Optional MEM_INIT_EN: after reset, fill every location with INIT_VALUE before accepting requests.
module memory_access_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int data_length = DATA_LENGTH,
  parameter int addr_length = ADDR_LENGTH,
  parameter logic [data_length-1:0] INIT_VALUE = {data_length{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [addr_length-1:0] req_addr,
  input  logic [data_length-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [data_length-1:0] rsp_rdata,
  output logic                   mem_read_write,
  output logic [addr_length-1:0] mem_address,
  output logic [data_length-1:0] mem_data_in,
  input  logic [data_length-1:0] mem_data_out
);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic        accept;

`ifdef MEM_INIT_EN
  localparam logic [addr_length:0] cnt_one = {{addr_length{1'b0}}, 1'b1};
  // MSB of the counter sets once every address has been issued.
  logic [addr_length:0] init_cnt;
  logic                 init_done;
  assign init_done = init_cnt[addr_length];
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Next-state decode; ISSUE uses the registered write strobe to tell write from read.
  always_comb begin
    next_state = state;
    case (state)
      INIT: begin
`ifdef MEM_INIT_EN
        if (init_done) begin
          next_state = IDLE;
        end else begin
          next_state = INIT;
        end
`else
        next_state = IDLE;
`endif
      end
      IDLE: begin
        if (accept) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (mem_read_write) begin
          next_state = IDLE;
        end else begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered memory pins and response channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= reset_state();
      mem_read_write <= 1'b0;
      mem_address    <= {addr_length{1'b0}};
      mem_data_in    <= {data_length{1'b0}};
      rsp_valid      <= 1'b0;
      rsp_rdata      <= {data_length{1'b0}};
`ifdef MEM_INIT_EN
      init_cnt       <= {(addr_length+1){1'b0}};
`endif
    end else begin
      state <= next_state;
      case (state)
        INIT: begin
`ifdef MEM_INIT_EN
          if (init_done) begin
            mem_read_write <= 1'b0;
          end else begin
            mem_read_write <= 1'b1;
            mem_address    <= init_cnt[addr_length-1:0];
            mem_data_in    <= INIT_VALUE;
            init_cnt       <= init_cnt + cnt_one;
          end
`else
          mem_read_write <= 1'b0;
`endif
        end
        IDLE: begin
          if (accept) begin
            mem_address    <= req_addr;
            mem_data_in    <= req_wdata;
            mem_read_write <= req_write;
          end else begin
            mem_read_write <= 1'b0;
          end
        end
        // Drop the strobe on the edge the memory commits, so a write happens once.
        ISSUE: mem_read_write <= 1'b0;
        CAPTURE: begin
          rsp_rdata <= mem_data_out;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: mem_read_write <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Directed scoreboard bench for memory_access_ctrl with a behavioural single-port memory.
// Define MEM_INIT_EN to also exercise the power-up fill with INIT_VALUE = 0x3C.
module tb_memory_access_ctrl;
  import memory_ctrl_pkg::*;

  localparam int DEPTH = 16;
`ifdef MEM_INIT_EN
  localparam logic [7:0] INIT_V = 8'h3C;
`else
  localparam logic [7:0] INIT_V = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       mem_read_write;
  logic [3:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  logic [7:0] mem   [DEPTH];
  logic [7:0] model [DEPTH];
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int cycle = 0;
  int last_accept = 0;

  always #5 clk = ~clk;

  memory_access_ctrl #(
    .data_length(8),
    .addr_length(4),
    .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Single-port memory: write on read_write=1, registered read of the addressed word.
  always @(posedge clk) begin
    if (mem_read_write) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_read_write) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("accept_timeout", (n < 40), 1);
    tick();
    last_accept = cycle;
    req_valid = 1'b0;
    if (wr) model[a] = d;
    else exp_q.push_back(model[a]);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    int w0;
    send(1'b1, a, d);
    check("wr_strobe", mem_read_write, 1);
    check("wr_addr", mem_address, a);
    check("wr_data", mem_data_in, d);
    check("wr_ready_low", req_ready, 0);
    w0 = wr_count;
    tick();
    check("wr_ready_back", req_ready, 1);
    check("wr_strobe_clr", mem_read_write, 0);
    check("wr_once", wr_count, w0 + 1);
  endtask

  task automatic do_read(input logic [3:0] a, input int hold);
    logic [7:0] e;
    send(1'b0, a, 8'h00);
    rsp_ready = 1'b0;
    check("rd_c1_valid", rsp_valid, 0);
    check("rd_c1_ready", req_ready, 0);
    tick();
    check("rd_c2_valid", rsp_valid, 0);
    tick();
    check("rd_c3_valid", rsp_valid, 1);
    e = exp_q.pop_front();
    check("rd_data", rsp_rdata, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_rdata, e);
      check("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_clr", rsp_valid, 0);
    check("rsp_idle", req_ready, 1);
    rsp_ready = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
`ifdef MEM_INIT_EN
    check("init_ready0", req_ready, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("init_ready_low", req_ready, 0);
    end
    tick();
    check("init_ready_c18", req_ready, 1);
    for (int i = 0; i < DEPTH; i++) model[i] = INIT_V;
`else
    check("idle_after_reset", req_ready, 1);
`endif
  endtask

  initial begin
    int p;
    int w0;
    logic [7:0] e;
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rw", mem_read_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_din", mem_data_in, 0);
    release_reset();

`ifdef MEM_INIT_EN
    do_read(4'd0, 0);
    do_read(4'd7, 0);
    do_read(4'd15, 0);
`endif

    do_write(4'd3, 8'hA5);
    do_read(4'd3, 0);
    do_read(4'd3, 5);

    for (int k = 0; k < DEPTH; k++) do_write(k[3:0], k[7:0] ^ 8'h5A);
    for (int k = 0; k < DEPTH; k++) begin
      p = last_accept;
      do_read(k[3:0], 0);
      if (k != 0) check("read_period", last_accept - p, 4);
    end

    // Write with fields changing while req_valid stays high in ISSUE.
    do_write(4'd6, 8'h77);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 8'h11;
    tick();
    model[5] = 8'h11;
    w0 = wr_count;
    req_write = 1'b0; req_addr = 4'd6; req_wdata = 8'h22;
    check("hold_addr", mem_address, 5);
    check("hold_din", mem_data_in, 8'h11);
    tick();
    req_valid = 1'b0;
    check("hold_rw_clr", mem_read_write, 0);
    tick();
    check("hold_one_write", wr_count, w0 + 1);
    do_read(4'd5, 0);
    do_read(4'd6, 0);

    // Read with fields changing during ISSUE/CAPTURE.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    tick();
    exp_q.push_back(model[3]);
    w0 = wr_count;
    req_addr = 4'd6; req_write = 1'b1; req_wdata = 8'hFF;
    tick();
    req_addr = 4'd0;
    tick();
    check("rdhold_valid", rsp_valid, 1);
    e = exp_q.pop_front();
    check("rdhold_data", rsp_rdata, e);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rdhold_clr", rsp_valid, 0);
    check("rdhold_no_write", wr_count, w0);

    // Reset while a read sits in CAPTURE.
    send(1'b0, 4'd3, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("rst_rd_valid", rsp_valid, 0);
    release_reset();
    tick();
    check("rst_rd_valid2", rsp_valid, 0);

    // Reset while a write is in ISSUE still commits the write.
    send(1'b1, 4'd9, 8'hC3);
    check("rst_wr_strobe", mem_read_write, 1);
    reset = 1'b1;
    tick();
    check("rst_wr_rw_clr", mem_read_write, 0);
    release_reset();
    do_read(4'd9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
